iter_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle ALU.
- Handles MUL/UMULL/SMULL-class and SDIV/UDIV-class operations that do not fit a single-cycle datapath.
- Sits beside the ALU in the execute stage. The control unit stalls the pipeline while Busy is high.
- Iterative shift-add multiply and restoring divide, one bit per clock, with signed/unsigned modes.

---
 rtl/iter_muldiv_pkg.sv | 19 +
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/iter_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_iter_muldiv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/iter_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and the iteration counter sizing helper.
package iter_muldiv_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_FINISH  = 2'd2;

  // Counter must be able to represent WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; one incrementer, used for operand
// magnitudes and for the final signed result.
module muldiv_sign_fix
  import iter_muldiv_pkg::*;
#(
  parameter int W2 = 64
) (
  input  logic [W2-1:0] i_val,
  input  logic          i_neg,
  output logic [W2-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W2-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle shift-add multiplier and restoring divider, one bit per clock.
// The single WIDTH+1 adder also forms operand2's magnitude and the remainder negate.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = cntWidth(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_isDiv;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_op1;
  logic               r_negA;
  logic               r_negB;
  logic [WIDTH-1:0]   r_res1;
  logic [WIDTH-1:0]   r_res2;
  logic               r_dbz;

  logic               w_negIn1;
  logic               w_negIn2;
  logic [2*WIDTH-1:0] w_opFix;
  logic               w_unusedOpHi;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_addA;
  logic [WIDTH:0]     w_addB;
  logic               w_addSub;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_remNext;
  logic [2*WIDTH-1:0] w_accNext;
  logic [2*WIDTH-1:0] w_resIn;
  logic [2*WIDTH-1:0] w_resFix;
  logic               w_divZero;
  logic [WIDTH-1:0]   w_fin1;
  logic [WIDTH-1:0]   w_fin2;
  logic               w_finDbz;

  assign w_negIn1 = Op[0] & Operand1[WIDTH-1];
  assign w_negIn2 = Op[0] & Operand2[WIDTH-1];

  muldiv_sign_fix #(.W2(2*WIDTH)) u_opFix (
    .i_val({{WIDTH{1'b0}}, Operand1}),
    .i_neg(w_negIn1),
    .o_val(w_opFix)
  );

  assign w_unusedOpHi = |w_opFix[2*WIDTH-1:WIDTH];
  assign w_mag1       = w_opFix[WIDTH-1:0];
  // In IDLE the adder computes 0 - Operand2, giving its magnitude for free.
  assign w_mag2       = w_negIn2 ? w_sum[WIDTH-1:0] : Operand2;

  always_comb begin
    w_addA   = '0;
    w_addB   = '0;
    w_addSub = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_addB   = {1'b0, Operand2};
        w_addSub = 1'b1;
      end
      S_COMPUTE: begin
        if (r_isDiv) begin
          w_addA   = r_acc[2*WIDTH-1:WIDTH-1];
          w_addB   = {1'b0, r_mcand};
          w_addSub = 1'b1;
        end else begin
          w_addA = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
          w_addB = r_acc[0] ? {1'b0, r_mcand} : '0;
        end
      end
      S_FINISH: begin
        w_addB   = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        w_addSub = 1'b1;
      end
      default: begin
        w_addSub = 1'b0;
      end
    endcase
  end

  assign w_sum = w_addA + (w_addSub ? ~w_addB : w_addB) + {{WIDTH{1'b0}}, w_addSub};

  // Partial remainder is below twice the divisor, so the trial difference fits
  // in WIDTH+1 bits and its top bit is a reliable sign.
  assign w_remNext = w_sum[WIDTH] ? r_acc[2*WIDTH-2:WIDTH-1] : w_sum[WIDTH-1:0];
  assign w_accNext = r_isDiv ? {w_remNext, r_acc[WIDTH-2:0], ~w_sum[WIDTH]}
                             : {w_sum, r_acc[WIDTH-1:1]};

  assign w_resIn = r_isDiv ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;

  muldiv_sign_fix #(.W2(2*WIDTH)) u_resFix (
    .i_val(w_resIn),
    .i_neg(r_negA),
    .o_val(w_resFix)
  );

  assign w_divZero = r_isDiv & (r_mcand == '0);

  always_comb begin
    w_fin1   = w_resFix[WIDTH-1:0];
    w_fin2   = w_resFix[2*WIDTH-1:WIDTH];
    w_finDbz = 1'b0;
    if (w_divZero) begin
      w_fin1   = '1;
      w_fin2   = r_op1;
      w_finDbz = 1'b1;
    end else if (r_isDiv) begin
      w_fin2 = r_negB ? w_sum[WIDTH-1:0] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_isDiv <= 1'b0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_op1   <= '0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_res1  <= '0;
      r_res2  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_COMPUTE;
            r_cnt   <= '0;
            r_isDiv <= Op[1];
            r_op1   <= Operand1;
            r_negA  <= w_negIn1 ^ w_negIn2;
            if (Op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_mag1};
              r_mcand <= w_mag2;
              r_negB  <= w_negIn1;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_mag2};
              r_mcand <= w_mag1;
              r_negB  <= 1'b0;
            end
          end
        end
        S_COMPUTE: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_res1  <= w_fin1;
          r_res2  <= w_fin2;
          r_dbz   <= w_finDbz;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Results are presented combinationally during the Done cycle, then held.
  assign Busy      = (r_state == S_COMPUTE);
  assign Done      = (r_state == S_FINISH);
  assign Result1   = Done ? w_fin1 : r_res1;
  assign Result2   = Done ? w_fin2 : r_res2;
  assign DivByZero = Done ? w_finDbz : r_dbz;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed-vector bench for iter_muldiv: 32-bit table plus 8-bit corner cases,
// start-ignore and mid-computation reset sequences.
module tb_iter_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, res1W, res2W;
  logic [7:0]  a8, b8, res1N, res2N;
  logic        busyW, doneW, dbzW, busyN, doneN, dbzN;

  iter_muldiv #(.WIDTH(32)) dutWide (
    .CLK(clk), .RESET(rst), .Start(start32), .Op(op32),
    .Operand1(a32), .Operand2(b32), .Result1(res1W), .Result2(res2W),
    .Busy(busyW), .Done(doneW), .DivByZero(dbzW)
  );

  iter_muldiv #(.WIDTH(8)) dutNarrow (
    .CLK(clk), .RESET(rst), .Start(start8), .Op(op8),
    .Operand1(a8), .Operand2(b8), .Result1(res1N), .Result2(res2N),
    .Busy(busyN), .Done(doneN), .DivByZero(dbzN)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        dbz;
  } vecT;

  int total = 0;
  int bad   = 0;

  bit          narrow;
  logic [63:0] gotR1, gotR2, holdR1;
  logic        gotDbz, gotDone, gotBusy, doneNext;
  int          gotLat, busyBad;

  logic        mBusy, mDone, mDbz;
  logic [63:0] mR1, mR2;
  assign mBusy = narrow ? busyN : busyW;
  assign mDone = narrow ? doneN : doneW;
  assign mDbz  = narrow ? dbzN  : dbzW;
  assign mR1   = narrow ? {56'd0, res1N} : {32'd0, res1W};
  assign mR2   = narrow ? {56'd0, res2N} : {32'd0, res2W};

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Launch one operation, scramble the operands after the accept edge, then
  // watch Busy until Done (bounded) and capture results plus the hold cycle.
  task automatic applyStimulus(input bit nar, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    narrow = nar;
    @(negedge clk);
    if (nar) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    a8 = ~a8; b8 = ~b8; a32 = ~a32; b32 = ~b32;
    op8 = ~op8; op32 = ~op32;
    gotLat  = 1;
    busyBad = 0;
    while (!mDone && gotLat < 200) begin
      if (!mBusy) busyBad++;
      @(negedge clk);
      gotLat++;
    end
    gotDone = mDone;
    gotBusy = mBusy;
    gotR1   = mR1;
    gotR2   = mR2;
    gotDbz  = mDbz;
    @(negedge clk);
    doneNext = mDone;
    holdR1   = mR1;
  endtask

  task automatic checkRun(input string name, input int w, input logic [31:0] r1,
                          input logic [31:0] r2, input logic dbz);
    checkOutput({name, " done"}, {63'd0, gotDone}, 64'd1);
    checkOutput({name, " latency"}, 64'(gotLat), 64'(w + 1));
    checkOutput({name, " busyGap"}, 64'(busyBad), 64'd0);
    checkOutput({name, " busyInDone"}, {63'd0, gotBusy}, 64'd0);
    checkOutput({name, " r1"}, gotR1, {32'd0, r1});
    checkOutput({name, " r2"}, gotR2, {32'd0, r2});
    checkOutput({name, " dbz"}, {63'd0, gotDbz}, {63'd0, dbz});
    checkOutput({name, " donePulse"}, {63'd0, doneNext}, 64'd0);
    checkOutput({name, " hold"}, holdR1, {32'd0, r1});
  endtask

  vecT vecs[13];
  int  doneSeen;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[6]  = '{2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
    vecs[7]  = '{2'b00, 32'd6,        32'd7,        32'd42,       32'd0,        1'b0};
    vecs[8]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[10] = '{2'b01, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[12] = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0};

    rst = 1'b1; narrow = 1'b0;
    start32 = 1'b0; start8 = 1'b0; op32 = 2'b00; op8 = 2'b00;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {62'd0, busyW, busyN}, 64'd0);
    checkOutput("reset done", {62'd0, doneW, doneN}, 64'd0);
    checkOutput("reset r1", {32'd0, res1W}, 64'd0);
    checkOutput("reset r2", {32'd0, res2W}, 64'd0);
    checkOutput("reset dbz", {63'd0, dbzW}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      checkRun($sformatf("vec%0d", i), 32, vecs[i].r1, vecs[i].r2, vecs[i].dbz);
    end

    applyStimulus(1'b1, 2'b01, 32'h80, 32'h7F);
    checkRun("w8 muls", 8, 32'hC0 & 32'hFF ? 32'h80 : 32'h0, 32'hC0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h80, 32'hFF);
    checkRun("w8 divs minneg", 8, 32'h80, 32'h00, 1'b0);
    applyStimulus(1'b1, 2'b10, 32'hC8, 32'h00);
    checkRun("w8 div0", 8, 32'hFF, 32'hC8, 1'b1);

    // Start pulsed mid-computation with new operands must not disturb 6*7.
    narrow = 1'b0;
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    start32 = 1'b1; op32 = 2'b10; a32 = 32'd9; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    gotLat = 0;
    while (!doneW && gotLat < 200) begin
      @(negedge clk);
      gotLat++;
    end
    checkOutput("ignore done", {63'd0, doneW}, 64'd1);
    checkOutput("ignore r1", {32'd0, res1W}, 64'd42);
    checkOutput("ignore r2", {32'd0, res2W}, 64'd0);
    @(negedge clk);
    checkOutput("ignore noRequeue", {63'd0, busyW}, 64'd0);

    // Reset ten cycles into a multiply discards it with no Done.
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd3; b32 = 32'd5;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset busy", {63'd0, busyW}, 64'd0);
    checkOutput("midReset r1", {32'd0, res1W}, 64'd0);
    checkOutput("midReset done", {63'd0, doneW}, 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (doneW) doneSeen++;
    end
    checkOutput("midReset noDone", 64'(doneSeen), 64'd0);

    applyStimulus(1'b0, 2'b10, 32'd100, 32'd7);
    checkRun("postReset div", 32, 32'd14, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
